lfsr_period_monitor: RTL and testbench
======================================

// Module: lfsr_period_monitor
// PURPOSE
//  Hardware self-check stage that sits directly downstream of lfsr.
//  - Samples lfsr.out every clock and syncs to its zero state.
//  - Verifies one full 2^WIDTH period: zero returns exactly on time, never early.
//  - Verifies no stuck value and an arithmetic signature over the period.
//  - Reports pass/fail and error flags for on-chip BIST; runs are triggered by start.
// PARAMETERS
//  WIDTH  20  sample width; must match lfsr WIDTH; expected period 2^WIDTH (WIDTH>=2)
// PORTS
//  clk             in   1        single clock; all logic on posedge
//  rst             in   1        reset, synchronous, active-low
//  start           in   1        one-cycle pulse; begins a run from IDLE or DONE
//  din             in   WIDTH    lfsr.out, sampled every posedge
//  busy            out  1        high in SYNC or RUN
//  done            out  1        high in DONE; held until next start or reset
//  pass            out  1        done & no error flag set
//  err_early_zero  out  1        din==0 before period end
//  err_no_zero     out  1        zero missing (sync timeout or not at period end)
//  err_stuck       out  1        din equal to previous sample
//  err_sig         out  1        period sum signature mismatch
//  cycle_count     out  WIDTH+1  sample index k at termination
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-low.
//  - rst==0 at a posedge: state=IDLE; all outputs 0; count, sum and prev cleared.
//    Applies mid-run: the run is abandoned and no flags are retained.
//  - States:
//    IDLE --start--> SYNC
//    SYNC --din==0--> RUN
//    SYNC --2^WIDTH samples with no zero--> DONE (err_no_zero)
//    RUN  --terminate--> DONE
//    DONE --start--> SYNC
//  - start is ignored while busy.
//  - On entry to SYNC, clear: flags, count, sum, done, pass.
//  - Counting:
//    - The zero sample that ends SYNC is index k=0.
//    - RUN samples k=1..2^WIDTH, one per posedge.
//    - count is WIDTH+1 bits; it never wraps.
//  - RUN checks, on the edge sampling index k:
//    - din==prev sample -> err_stuck; terminate with cycle_count=k.
//    - din==0 and k<2^WIDTH -> err_early_zero; terminate with cycle_count=k.
//    - k==2^WIDTH: din!=0 -> err_no_zero.
//    - k==2^WIDTH: sum != 2^(WIDTH-1) -> err_sig.
//    - k==2^WIDTH: terminate with cycle_count=2^WIDTH.
//    - Otherwise: sum <= sum + din (mod 2^WIDTH).
//    - Signature: the sum of all 2^WIDTH distinct values mod 2^WIDTH is 2^(WIDTH-1).
//  - Precedence on the same edge: stuck > early_zero; period-end checks apply only at k==2^WIDTH.
//  - Only one terminating flag is set per run, except that err_no_zero and err_sig
//    may both be set at period end.
//  - Latency: done, pass, flags and cycle_count are registered on the deciding edge
//    and are visible the following cycle.
//  - busy falls on that same edge.
//  - SYNC timeout: count the samples in SYNC. The 2^WIDTH-th non-zero sample gives
//    err_no_zero with cycle_count=2^WIDTH.
//  - Simultaneous start and deciding edge is not possible (start is ignored while busy).
//  - start in DONE clears the previous result on the next edge.
// TESTING (WIDTH=4, period 16)
//  - Hold rst=0 for 2 edges, din random -> busy=done=pass=0, all err=0, cycle_count=0.
//  - Connect real lfsr (WIDTH=4), pulse start -> busy within 1 cycle; done within 33 cycles;
//    pass=1; all err=0; cycle_count=16.
//  - Model stream 0, then 1..15 with 0 injected at k=7 -> done; err_early_zero=1;
//    cycle_count=7; pass=0.
//  - Model stream 0,3,3 -> err_stuck=1, cycle_count=2; din stuck at 5 from start ->
//    err_no_zero=1, cycle_count=16.
//  - Model full period with value 9 replaced by 8 (non-adjacent) -> zero at k=16;
//    err_sig=1; pass=0; other err=0.
//  - Assert rst=0 at k=10 of a good run -> all outputs 0 next cycle; then start ->
//    clean pass, cycle_count=16.

Source files
------------

// File: rtl/lfsr_period_monitor.sv
// Period self-check for a full-cycle (2^WIDTH) LFSR stream: locks onto the zero
// state, then verifies on-time zero return, no stuck samples and a sum signature.
module lfsr_period_monitor #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_early_zero,
  output logic             err_no_zero,
  output logic             err_stuck,
  output logic             err_sig,
  output logic [WIDTH:0]   cycle_count
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [CW-1:0]    PERIOD = CW'(1) << WIDTH;
  localparam logic [WIDTH-1:0] SIG    = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    k_c;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             early_q, early_d;
  logic             nozero_q, nozero_d;
  logic             stuck_q, stuck_d;
  logic             sig_q, sig_d;
  logic [CW-1:0]    cc_q, cc_d;

  // Next-state and result logic; every terminating branch lands in DONE.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sum_d    = sum_q;
    prev_d   = din;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    early_d  = early_q;
    nozero_d = nozero_q;
    stuck_d  = stuck_q;
    sig_d    = sig_q;
    cc_d     = cc_q;
    k_c      = count_q + CW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SYNC;
          busy_d   = 1'b1;
          count_d  = '0;
          sum_d    = '0;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          early_d  = 1'b0;
          nozero_d = 1'b0;
          stuck_d  = 1'b0;
          sig_d    = 1'b0;
          cc_d     = '0;
        end
      end
      S_SYNC: begin
        if (din == '0) begin
          state_d = S_RUN;
          count_d = '0;
        end else if (k_c == PERIOD) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          nozero_d = 1'b1;
          cc_d     = PERIOD;
        end else begin
          count_d = k_c;
        end
      end
      S_RUN: begin
        count_d = k_c;
        if (din == prev_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          stuck_d = 1'b1;
          cc_d    = k_c;
        end else if (din == '0 && k_c != PERIOD) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          early_d = 1'b1;
          cc_d    = k_c;
        end else if (k_c == PERIOD) begin
          // The final sample is the returning zero, so it is not summed.
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          nozero_d = (din != '0);
          sig_d    = (sum_q != SIG);
          pass_d   = (din == '0) && (sum_q == SIG);
          cc_d     = PERIOD;
        end else begin
          sum_d = sum_q + din;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      sum_q    <= '0;
      prev_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      early_q  <= 1'b0;
      nozero_q <= 1'b0;
      stuck_q  <= 1'b0;
      sig_q    <= 1'b0;
      cc_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      prev_q   <= prev_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      early_q  <= early_d;
      nozero_q <= nozero_d;
      stuck_q  <= stuck_d;
      sig_q    <= sig_d;
      cc_q     <= cc_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_early_zero = early_q;
  assign err_no_zero    = nozero_q;
  assign err_stuck      = stuck_q;
  assign err_sig        = sig_q;
  assign cycle_count    = cc_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Bench for lfsr_period_monitor at WIDTH=4: directed and randomized sample
// streams checked against a stream-level reference model.
module tb_lfsr_period_monitor;

  localparam int unsigned W = 4;
  localparam int          P = 16;

  typedef logic [W-1:0] q_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] din;
  logic         busy, done, pass;
  logic         err_early_zero, err_no_zero, err_stuck, err_sig;
  logic [W:0]   cycle_count;

  int total = 0;
  int bad   = 0;

  lfsr_period_monitor #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .din            (din),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_early_zero (err_early_zero),
    .err_no_zero    (err_no_zero),
    .err_stuck      (err_stuck),
    .err_sig        (err_sig),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flag vector order: {done, pass, early_zero, no_zero, stuck, sig}
  function automatic logic [5:0] obs_flags();
    return {done, pass, err_early_zero, err_no_zero, err_stuck, err_sig};
  endfunction

  // Reference: find the zero in the first P samples, then walk one period.
  function automatic void model(input q_t s, output logic [5:0] f, output int cc);
    int z = -1;
    int sum = 0;
    logic [W-1:0] v, p;
    bit nz, sg;
    f  = '0;
    cc = 0;
    for (int i = 0; i < P; i++) if (z < 0 && s[i] == 0) z = i;
    if (z < 0) begin
      f = 6'b100100; cc = P; return;
    end
    for (int k = 1; k <= P; k++) begin
      v = s[z+k];
      p = s[z+k-1];
      if (v == p) begin f = 6'b100010; cc = k; return; end
      if (v == 0 && k < P) begin f = 6'b101000; cc = k; return; end
      if (k == P) begin
        nz = (v != 0);
        sg = ((sum % P) != P / 2);
        f  = {1'b1, !(nz || sg), 1'b0, nz, 1'b0, sg};
        cc = P;
        return;
      end
      sum += int'(v);
    end
  endfunction

  // A legal full-period stream: nonzero lead-in, zero, shuffled 1..15, zero, padding.
  function automatic q_t make_good(input int pre);
    q_t s;
    int a[15];
    int j, t;
    for (int i = 0; i < pre; i++) s.push_back(W'($urandom_range(1, P - 1)));
    s.push_back('0);
    for (int i = 0; i < 15; i++) a[i] = i + 1;
    for (int i = 14; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = a[i]; a[i] = a[j]; a[j] = t;
    end
    for (int i = 0; i < 15; i++) s.push_back(W'(a[i]));
    s.push_back('0);
    for (int i = 0; i < 3; i++) s.push_back(W'($urandom_range(0, P - 1)));
    return s;
  endfunction

  task automatic run(input string tag, input q_t s, input int mid_start);
    logic [5:0] ef;
    int ecc;
    bit got = 0;
    start = 1'b1;
    din   = W'($urandom_range(1, P - 1));
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_rise"}, busy, 1);
    for (int i = 0; i < s.size() && !got; i++) begin
      din   = s[i];
      start = (i == mid_start);
      @(posedge clk); #1;
      start = 1'b0;
      if (done) got = 1;
    end
    chk({tag, ".done_seen"}, got, 1);
    model(s, ef, ecc);
    chk({tag, ".flags"}, obs_flags(), ef);
    chk({tag, ".cycle_count"}, cycle_count, ecc);
    chk({tag, ".busy_fall"}, busy, 0);
  endtask

  initial begin
    q_t s;
    rst   = 1'b0;
    start = 1'b0;
    din   = W'($urandom);

    // Reset held for two edges with random din
    repeat (2) begin
      @(posedge clk); #1;
      din = W'($urandom);
    end
    chk("rst.flags", obs_flags(), 0);
    chk("rst.busy", busy, 0);
    chk("rst.cycle_count", cycle_count, 0);
    rst = 1'b1;

    // Good periods, including a start pulse while busy that must be ignored
    run("good0", make_good(0), -1);
    run("good1", make_good(3), 2);
    run("good2", make_good(1), -1);

    // Results hold in DONE without a new start
    repeat (3) @(posedge clk);
    #1;
    chk("hold.done", done, 1);

    // Early zero at k=7
    s = {};
    s.push_back('0);
    for (int i = 1; i <= 15; i++) s.push_back(i == 7 ? W'(0) : W'(i));
    s.push_back('0);
    run("early7", s, -1);

    // Stuck at k=2
    s = {};
    s.push_back(W'(0)); s.push_back(W'(3)); s.push_back(W'(3));
    s.push_back(W'(1)); s.push_back(W'(2));
    run("stuck2", s, -1);

    // No zero ever: sync timeout
    s = {};
    for (int i = 0; i < 20; i++) s.push_back(W'(5));
    run("nozero", s, -1);

    // Value 9 replaced by 8, kept apart from the real 8
    s = {};
    s.push_back('0);
    for (int i = 1; i <= 8; i++) s.push_back(W'(i));
    for (int i = 10; i <= 15; i++) s.push_back(W'(i));
    s.push_back(W'(8));
    s.push_back('0);
    s.push_back(W'(4));
    run("sig", s, -1);

    // Randomly corrupted periods
    for (int r = 0; r < 8; r++) begin
      int pos;
      s   = make_good(int'($urandom_range(0, 3)));
      pos = int'($urandom_range(0, s.size() - 4));
      s[pos] = W'($urandom_range(0, P - 1));
      run($sformatf("rand%0d", r), s, -1);
    end

    // Reset at k=10 abandons the run
    s = make_good(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din = s[i];
      @(posedge clk); #1;
    end
    chk("midrst.busy_before", busy, 1);
    din = s[10];
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst.flags", obs_flags(), 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.cycle_count", cycle_count, 0);
    rst = 1'b1;
    run("post_rst", make_good(2), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
